// File: rtl/flag_issue_scheduler.sv
// Flag-aware issue stage: owns NZCV, tracks in-flight flag setters,
// stalls conditional instructions until flags resolve, issues with exec/annul.
module flag_issue_scheduler #(
    parameter int unsigned MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       id_s,
    output logic       id_ready,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic       issue_exec,
    output logic       issue_s,
    input  logic       ex_flag_valid,
    input  logic [3:0] ex_flags,
    input  logic       flush,
    output logic [3:0] status,
    output logic       stall,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_INFLIGHT);

    typedef enum logic {ST_RUN, ST_STALL} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_pend;
    logic             r_issue_valid;
    logic             r_issue_exec;
    logic             r_issue_s;
    logic [3:0]       r_status;
    logic             r_err;

    logic             w_needs;
    logic             w_pend_zero;
    logic             w_resolved;
    logic [3:0]       w_flags;
    logic             w_pass;
    logic             w_s_next;
    logic             w_accept;
    logic             w_inc;
    logic             w_dec;

    // ARM condition evaluation, flags ordered {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf & !z;
            4'h9:    cond_pass = !cf | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Flag source selection, readiness and accept
    always_comb begin
        w_needs     = (id_cond != 4'hE) && (id_cond != 4'hF);
        w_pend_zero = (r_pend == '0);
        w_resolved  = w_pend_zero || ((r_pend == CNT_W'(1)) && ex_flag_valid);
        w_flags     = w_pend_zero ? r_status : ex_flags;
        w_pass      = cond_pass(id_cond, w_flags);
        w_s_next    = id_s & w_pass;
        id_ready    = !flush
                    && (!r_issue_valid || issue_ready)
                    && (!w_needs || w_resolved)
                    && !(id_s && (r_pend == PEND_MAX) && !ex_flag_valid);
        w_accept    = id_valid & id_ready;
        w_inc       = w_accept & w_s_next;
        w_dec       = ex_flag_valid & !w_pend_zero;
    end

    // Issue slot: load on accept, hold under backpressure, drop on handshake or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue_exec  <= 1'b0;
            r_issue_s     <= 1'b0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
            r_issue_exec  <= 1'b0;
            r_issue_s     <= 1'b0;
        end else if (w_accept) begin
            r_issue_valid <= 1'b1;
            r_issue_exec  <= w_pass;
            r_issue_s     <= w_s_next;
        end else if (issue_ready) begin
            r_issue_valid <= 1'b0;
            r_issue_exec  <= 1'b0;
            r_issue_s     <= 1'b0;
        end
    end

    // Pending flag-setter count, status register and sticky underflow error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= '0;
            r_status <= 4'b0000;
            r_err    <= 1'b0;
        end else begin
            if (ex_flag_valid) begin
                r_status <= ex_flags;
            end
            if (ex_flag_valid && w_pend_zero) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_pend <= '0;
            end else if (w_inc && !w_dec) begin
                r_pend <= r_pend + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                r_pend <= r_pend - CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: stall only on unresolved flags, never on backpressure
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (!flush && id_valid && w_needs && !w_resolved) begin
                    w_state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (flush || w_resolved || !id_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    assign issue_valid = r_issue_valid;
    assign issue_exec  = r_issue_exec;
    assign issue_s     = r_issue_s;
    assign status      = r_status;
    assign err         = r_err;
    assign stall       = (r_state == ST_STALL);

endmodule
